// File: rtl/alu_pkg.sv
// Shared definitions for the time-shared ALU slice: widths, opcodes and FSM states.
package alu_pkg;

    localparam int unsigned OPND_W = 2;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned RES_W  = 3;
    localparam int unsigned CNT_W  = 8;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W-1:0] OP_SHR = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response handshake bundle between the two requesters, the consumer and the shared ALU.
interface alu_share_arb_if;
    import alu_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [OPND_W-1:0] req0_a;
    logic [OPND_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [OPND_W-1:0] req1_a;
    logic [OPND_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [RES_W-1:0]  rsp_result;
    logic              rsp_overflow;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_overflow
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_overflow
    );

endinterface

// File: rtl/alu_core.sv
// Combinational 2-bit ALU; overflow is always bit 2 of A+B regardless of opcode.
module alu_core
    import alu_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [RES_W-1:0]  result,
    output logic              overflow
);

    logic [RES_W-1:0] sum;
    logic [RES_W-1:0] diff;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        overflow = sum[2];
        result   = '0;
        case (op)
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
            OP_AND:  result = {1'b0, a & b};
            OP_OR:   result = {1'b0, a | b};
            OP_XOR:  result = {1'b0, a ^ b};
            OP_NOT:  result = {1'b0, ~a};
            OP_SHL:  result = {a, 1'b0};
            OP_SHR:  result = {2'b00, a[1]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester arbiter/sequencer sharing one alu_core; holds the tagged result until consumed
// and keeps a wrapping completion counter plus a sticky overflow flag.
module alu_share_arb
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    alu_share_arb_if.slave   bus,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] done_cnt,
    output logic             ovf_sticky
);

    state_t            state;
    logic              last_grant;
    logic [OPND_W-1:0] a_q;
    logic [OPND_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic              id_q;

    logic              gnt0;
    logic              gnt1;
    logic              rsp_hs;
    logic [RES_W-1:0]  alu_result;
    logic              alu_ovf;

    // On a tie the requester that did not win last time is served; last_grant=1 favours req0.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == ST_IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = last_grant;
                gnt1 = ~last_grant;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign rsp_hs         = (state == ST_RESP) && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            id_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_q        <= gnt1 ? bus.req1_a  : bus.req0_a;
                        b_q        <= gnt1 ? bus.req1_b  : bus.req0_b;
                        op_q       <= gnt1 ? bus.req1_op : bus.req0_op;
                        id_q       <= gnt1;
                        last_grant <= gnt1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A clear on the same edge as a handshake drops that handshake from the statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt   <= '0;
            ovf_sticky <= 1'b0;
        end else if (clr_stats) begin
            done_cnt   <= '0;
            ovf_sticky <= 1'b0;
        end else if (rsp_hs) begin
            done_cnt   <= done_cnt + 8'd1;
            ovf_sticky <= ovf_sticky | alu_ovf;
        end
    end

    alu_core u_alu (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .result   (alu_result),
        .overflow (alu_ovf)
    );

    assign bus.rsp_valid    = (state == ST_RESP);
    assign bus.rsp_id       = id_q;
    assign bus.rsp_result   = alu_result;
    assign bus.rsp_overflow = alu_ovf;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: a reference model queues expected responses, a monitor checks them.
module tb_alu_share_arb;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_stats = 1'b0;
    logic [7:0] done_cnt;
    logic       ovf_sticky;

    alu_share_arb_if bus();

    alu_share_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .clr_stats  (clr_stats),
        .done_cnt   (done_cnt),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int res;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: busy while a response is outstanding; who won last; statistics.
    int m_busy = 0;
    int m_last = 1;
    int m_cnt = 0;
    int m_st = 0;
    int m_cur_ovf = 0;

    function automatic int ref_res(int a, int b, int op);
        case (op)
            0: return (a + b) % 8;
            1: return (a - b + 8) % 8;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return 3 - a;
            6: return (a * 2) % 8;
            default: return a / 2;
        endcase
    endfunction

    function automatic int winner(int v0, int v1, int last);
        if (v0 != 0 && v1 != 0) return (last == 0) ? 1 : 0;
        if (v0 != 0) return 0;
        if (v1 != 0) return 1;
        return -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advances on each rising edge using the stable bench-driven inputs.
    always @(posedge clk) begin
        int hs, w, a, b, op;
        if (rst_n) begin
            hs = (m_busy != 0 && bus.rsp_ready) ? 1 : 0;
            if (clr_stats) begin
                m_cnt = 0;
                m_st  = 0;
            end else if (hs != 0) begin
                m_cnt = (m_cnt + 1) % 256;
                m_st  = m_st | m_cur_ovf;
            end
            if (hs != 0) begin
                m_busy = 0;
            end else if (m_busy == 0) begin
                w = winner(int'(bus.req0_valid), int'(bus.req1_valid), m_last);
                if (w >= 0) begin
                    a  = (w == 1) ? int'(bus.req1_a)  : int'(bus.req0_a);
                    b  = (w == 1) ? int'(bus.req1_b)  : int'(bus.req0_b);
                    op = (w == 1) ? int'(bus.req1_op) : int'(bus.req0_op);
                    m_cur_ovf = (a + b) / 4;
                    exp_q.push_back('{w, ref_res(a, b, op), m_cur_ovf});
                    m_last = w;
                    m_busy = 1;
                end
            end
        end
    end

    // Monitor: sample DUT mid-cycle and pop the scoreboard on each response handshake.
    always @(negedge clk) begin
        exp_t e;
        int   w;
        chk("rsp_valid", int'(bus.rsp_valid), (m_busy != 0) ? 1 : 0);
        w = (m_busy != 0) ? -1 : winner(int'(bus.req0_valid), int'(bus.req1_valid), m_last);
        chk("req0_ready", int'(bus.req0_ready), (w == 0) ? 1 : 0);
        chk("req1_ready", int'(bus.req1_ready), (w == 1) ? 1 : 0);
        chk("done_cnt", int'(done_cnt), m_cnt);
        chk("ovf_sticky", int'(ovf_sticky), m_st);
        if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no pending response at %0t", $time);
            end else begin
                e = exp_q[0];
                chk("rsp_id", int'(bus.rsp_id), e.id);
                chk("rsp_result", int'(bus.rsp_result), e.res);
                chk("rsp_overflow", int'(bus.rsp_overflow), e.ovf);
                if (bus.rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp_ready = 1'b1;
        clr_stats = 1'b0;
    endtask

    task automatic set_req0(int a, int b, int op);
        bus.req0_valid = 1'b1;
        bus.req0_a  = 2'(a);
        bus.req0_b  = 2'(b);
        bus.req0_op = 3'(op);
    endtask

    task automatic set_req1(int a, int b, int op);
        bus.req1_valid = 1'b1;
        bus.req1_a  = 2'(a);
        bus.req1_b  = 2'(b);
        bus.req1_op = 3'(op);
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_last = 1;
        m_cnt  = 0;
        m_st   = 0;
        m_cur_ovf = 0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        #1;
        chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
        chk("reset_rsp_id", int'(bus.rsp_id), 0);
        chk("reset_rsp_result", int'(bus.rsp_result), 0);
        chk("reset_rsp_overflow", int'(bus.rsp_overflow), 0);
        chk("reset_done_cnt", int'(done_cnt), 0);
        chk("reset_ovf_sticky", int'(ovf_sticky), 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Single op on req0: 3+2 = 5 with overflow.
        set_req0(3, 2, 0);
        step();
        bus.req0_valid = 1'b0;
        step();
        chk("single_done_cnt", int'(done_cnt), 1);
        chk("single_ovf_sticky", int'(ovf_sticky), 1);
        step();

        // Continuous tie: grants must alternate.
        set_req0(0, 1, 1);
        set_req1(3, 0, 6);
        repeat (8) step();
        idle_inputs();
        step();

        // Back-pressure with a competing request held high.
        set_req1(1, 2, 3);
        step();
        bus.req1_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        set_req0(2, 2, 0);
        repeat (5) step();
        bus.rsp_ready = 1'b1;
        step();
        step();
        idle_inputs();
        step();

        // Every opcode with A=2, B=3.
        for (int op = 0; op < 8; op++) begin
            set_req0(2, 3, op);
            step();
            bus.req0_valid = 1'b0;
            step();
        end

        // Counter wrap after 256 handshakes.
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        for (int i = 0; i < 256; i++) begin
            set_req1(i % 4, (i / 4) % 4, (i / 16) % 8);
            step();
            bus.req1_valid = 1'b0;
            step();
        end
        chk("wrap_done_cnt", int'(done_cnt), 0);

        // Clear coincident with a handshake of an overflowing op.
        set_req0(3, 3, 0);
        step();
        bus.req0_valid = 1'b0;
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("clr_hs_done_cnt", int'(done_cnt), 0);
        chk("clr_hs_ovf_sticky", int'(ovf_sticky), 0);
        step();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req0_a  = 2'($urandom_range(0, 3));
            bus.req0_b  = 2'($urandom_range(0, 3));
            bus.req0_op = 3'($urandom_range(0, 7));
            bus.req1_a  = 2'($urandom_range(0, 3));
            bus.req1_b  = 2'($urandom_range(0, 3));
            bus.req1_op = 3'($urandom_range(0, 7));
            bus.rsp_ready = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
            clr_stats = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
            step();
        end
        idle_inputs();
        step(); step();

        // Reset while a response is held, then a tie must go to req0.
        set_req1(1, 1, 0);
        bus.rsp_ready = 1'b0;
        step();
        bus.req1_valid = 1'b0;
        step();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_rsp_valid", int'(bus.rsp_valid), 0);
        chk("midreset_done_cnt", int'(done_cnt), 0);
        step(); step();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req0(1, 0, 0);
        set_req1(2, 0, 0);
        step();
        idle_inputs();
        #1;
        chk("post_reset_tie_id", int'(bus.rsp_id), 0);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
